// File: rtl/debug_sequencer_if.sv
// debug_sequencer_if: JTAG-bridge and core-side signals of the debug sequencer.
// The master side is the bridge/core environment; the slave side is the sequencer.
interface debug_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  debug_seize;
    logic                  debug_run;
    logic [ADDR_WIDTH-1:0] debug_addr;
    logic                  debug_wr_en;
    logic [DATA_WIDTH-1:0] debug_wr_val;
    logic                  debug_stopped;
    logic [DATA_WIDTH-1:0] debug_val;
    logic                  instr_boundary;
    logic                  core_stall;
    logic                  ucode_start;
    logic [ADDR_WIDTH-1:0] ucode_addr;
    logic                  ucode_done;
    logic                  ucode_wr_en;
    logic [DATA_WIDTH-1:0] ucode_wr_val;
    logic [DATA_WIDTH-1:0] ucode_rd_val;
    logic                  proc_timeout;

    modport master (
        output debug_seize, debug_run, debug_addr, debug_wr_en, debug_wr_val,
               instr_boundary, ucode_done, ucode_wr_en, ucode_wr_val,
        input  debug_stopped, debug_val, core_stall, ucode_start, ucode_addr,
               ucode_rd_val, proc_timeout
    );

    modport slave (
        input  debug_seize, debug_run, debug_addr, debug_wr_en, debug_wr_val,
               instr_boundary, ucode_done, ucode_wr_en, ucode_wr_val,
        output debug_stopped, debug_val, core_stall, ucode_start, ucode_addr,
               ucode_rd_val, proc_timeout
    );
endinterface

// File: rtl/debug_sequencer.sv
// debug_sequencer: halts the core at an instruction boundary, launches debug microcode
// procedures with a timeout watchdog, and holds the JTAG <-> microcode value registers.
module debug_sequencer #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    PROC_TIMEOUT = 4096,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_VAL  = 16'hDEAD
) (
    input logic              cpu_clk,
    input logic              reset,
    debug_sequencer_if.slave dbg
);
    localparam int CW = $clog2(PROC_TIMEOUT);

    typedef enum logic [2:0] {RUNNING, SEIZING, STOPPED, LAUNCH, EXEC} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic                  w_expire;
    logic                  r_stopped;
    logic                  r_timeout;
    logic [DATA_WIDTH-1:0] r_val;
    logic [DATA_WIDTH-1:0] r_rd_val;
    logic [ADDR_WIDTH-1:0] r_addr;

    assign w_expire = r_cnt == CW'(PROC_TIMEOUT - 1);

    always_ff @(posedge cpu_clk or posedge reset)
        if (reset) r_state <= RUNNING;
        else       r_state <= w_next;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RUNNING: w_next = dbg.debug_seize ? SEIZING : RUNNING;
            SEIZING: w_next = !dbg.debug_seize ? RUNNING : dbg.instr_boundary ? STOPPED : SEIZING;
            STOPPED: w_next = dbg.debug_run ? LAUNCH : !dbg.debug_seize ? RUNNING : STOPPED;
            LAUNCH:  w_next = EXEC;
            EXEC:    w_next = (dbg.ucode_done || w_expire) ? STOPPED : EXEC;
            default: w_next = RUNNING;
        endcase
    end

    always_comb begin
        dbg.core_stall  = (r_state == SEIZING && dbg.instr_boundary) || r_state == STOPPED ||
                          r_state == LAUNCH || r_state == EXEC;
        dbg.ucode_start = r_state == LAUNCH;
    end

    // A done on the expiry cycle wins, so the timeout only fires without done.
    always_ff @(posedge cpu_clk or posedge reset)
        if (reset) begin
            r_cnt     <= '0;
            r_stopped <= 1'b0;
            r_timeout <= 1'b0;
            r_val     <= '0;
            r_rd_val  <= '0;
            r_addr    <= '0;
        end else begin
            r_stopped <= w_next == STOPPED;
            if (r_state == LAUNCH) r_cnt <= '0;
            else if (r_state == EXEC && !w_expire) r_cnt <= r_cnt + CW'(1);
            if (r_state == STOPPED && dbg.debug_run) begin
                r_addr    <= dbg.debug_addr;
                r_timeout <= 1'b0;
            end
            if (r_state == EXEC && !dbg.ucode_done && w_expire) begin
                r_timeout <= 1'b1;
                r_val     <= TIMEOUT_VAL;
            end else if (dbg.ucode_wr_en) r_val <= dbg.ucode_wr_val;
            if (dbg.debug_wr_en) r_rd_val <= dbg.debug_wr_val;
        end

    assign dbg.debug_stopped = r_stopped;
    assign dbg.debug_val     = r_val;
    assign dbg.ucode_rd_val  = r_rd_val;
    assign dbg.ucode_addr    = r_addr;
    assign dbg.proc_timeout  = r_timeout;
endmodule

// File: tb/tb_debug_sequencer.sv
// tb_debug_sequencer: directed stimulus with hand-computed expectations for debug_sequencer.
module tb_debug_sequencer;
    logic cpu_clk = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    debug_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dbg ();

    debug_sequencer #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .PROC_TIMEOUT(16), .TIMEOUT_VAL(16'hDEAD)
    ) dut (
        .cpu_clk(cpu_clk),
        .reset  (reset),
        .dbg    (dbg)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stopped"}, 32'(dbg.debug_stopped), 0);
        chk({tag, "_stall"},   32'(dbg.core_stall), 0);
        chk({tag, "_start"},   32'(dbg.ucode_start), 0);
        chk({tag, "_val"},     32'(dbg.debug_val), 0);
        chk({tag, "_rdval"},   32'(dbg.ucode_rd_val), 0);
        chk({tag, "_addr"},    32'(dbg.ucode_addr), 0);
        chk({tag, "_tmo"},     32'(dbg.proc_timeout), 0);
    endtask

    initial begin
        dbg.debug_seize = 0; dbg.debug_run = 0; dbg.debug_addr = '0;
        dbg.debug_wr_en = 0; dbg.debug_wr_val = '0; dbg.instr_boundary = 0;
        dbg.ucode_done = 0; dbg.ucode_wr_en = 0; dbg.ucode_wr_val = '0;
        tick; tick;
        chk_all_zero("reset");
        reset = 0;
        // halt at a boundary
        dbg.debug_seize = 1;
        tick;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("seizing_stall", 32'(dbg.core_stall), 0);
            chk("seizing_stopped", 32'(dbg.debug_stopped), 0);
        end
        dbg.instr_boundary = 1; #1;
        chk("boundary_stall", 32'(dbg.core_stall), 1);
        chk("boundary_stopped", 32'(dbg.debug_stopped), 0);
        tick; dbg.instr_boundary = 0; #1;
        chk("halt_stopped", 32'(dbg.debug_stopped), 1);
        chk("halt_stall", 32'(dbg.core_stall), 1);
        chk("halt_start", 32'(dbg.ucode_start), 0);
        // JTAG value write, one cycle latency
        dbg.debug_wr_en = 1; dbg.debug_wr_val = 16'hBEEF; #1;
        chk("rdval_before", 32'(dbg.ucode_rd_val), 0);
        tick; dbg.debug_wr_en = 0; #1;
        chk("rdval_after", 32'(dbg.ucode_rd_val), 32'hBEEF);
        // procedure with done and result write
        dbg.debug_run = 1; dbg.debug_addr = 8'h12; #1;
        chk("run_stopped_still", 32'(dbg.debug_stopped), 1);
        tick; dbg.debug_run = 0; dbg.debug_addr = 0; #1;
        chk("launch_start", 32'(dbg.ucode_start), 1);
        chk("launch_addr", 32'(dbg.ucode_addr), 32'h12);
        chk("launch_stopped", 32'(dbg.debug_stopped), 0);
        chk("launch_stall", 32'(dbg.core_stall), 1);
        tick;
        chk("exec_start", 32'(dbg.ucode_start), 0);
        chk("exec_stopped", 32'(dbg.debug_stopped), 0);
        tick; tick;
        dbg.ucode_done = 1; dbg.ucode_wr_en = 1; dbg.ucode_wr_val = 16'h1234; #1;
        chk("done_stopped", 32'(dbg.debug_stopped), 0);
        tick; dbg.ucode_done = 0; dbg.ucode_wr_en = 0; #1;
        chk("done_val", 32'(dbg.debug_val), 32'h1234);
        chk("done_stopped_rise", 32'(dbg.debug_stopped), 1);
        chk("done_tmo", 32'(dbg.proc_timeout), 0);
        // timeout: 16 EXEC cycles, a run during EXEC is ignored
        dbg.debug_run = 1; dbg.debug_addr = 8'h34;
        tick; dbg.debug_run = 0; #1;
        chk("t_launch_start", 32'(dbg.ucode_start), 1);
        for (int i = 0; i < 16; i++) begin
            dbg.debug_run = (i == 5); dbg.debug_addr = 8'h55;
            tick;
        end
        dbg.debug_run = 0; #1;
        chk("t_last_exec_stopped", 32'(dbg.debug_stopped), 0);
        chk("t_last_exec_tmo", 32'(dbg.proc_timeout), 0);
        chk("t_run_ignored_addr", 32'(dbg.ucode_addr), 32'h34);
        tick;
        chk("t_stopped", 32'(dbg.debug_stopped), 1);
        chk("t_tmo", 32'(dbg.proc_timeout), 1);
        chk("t_val", 32'(dbg.debug_val), 32'hDEAD);
        chk("t_start_quiet", 32'(dbg.ucode_start), 0);
        // next run clears the flag; done on the expiry cycle is a success
        dbg.debug_run = 1; dbg.debug_addr = 8'h56;
        tick; dbg.debug_run = 0; #1;
        chk("e_launch_tmo_clr", 32'(dbg.proc_timeout), 0);
        for (int i = 0; i < 16; i++) tick;
        dbg.ucode_done = 1;
        tick; dbg.ucode_done = 0; #1;
        chk("e_stopped", 32'(dbg.debug_stopped), 1);
        chk("e_tmo", 32'(dbg.proc_timeout), 0);
        chk("e_val", 32'(dbg.debug_val), 32'hDEAD);
        // seize dropped in EXEC takes effect only after done
        dbg.debug_run = 1; dbg.debug_addr = 8'h60;
        tick; dbg.debug_run = 0; dbg.debug_seize = 0;
        tick; tick; #1;
        chk("drop_exec_stall", 32'(dbg.core_stall), 1);
        chk("drop_exec_stopped", 32'(dbg.debug_stopped), 0);
        dbg.ucode_done = 1;
        tick; dbg.ucode_done = 0; #1;
        chk("drop_done_stopped", 32'(dbg.debug_stopped), 1);
        chk("drop_done_stall", 32'(dbg.core_stall), 1);
        tick;
        chk("drop_run_stopped", 32'(dbg.debug_stopped), 0);
        chk("drop_run_stall", 32'(dbg.core_stall), 0);
        // seize withdrawn before/with boundary returns to RUNNING
        dbg.debug_seize = 1;
        tick; dbg.debug_seize = 0;
        tick;
        dbg.instr_boundary = 1; #1;
        chk("wd_running_stall", 32'(dbg.core_stall), 0);
        tick; dbg.instr_boundary = 0;
        dbg.debug_seize = 1;
        tick; dbg.debug_seize = 0; dbg.instr_boundary = 1; #1;
        chk("wd_boundary_stall", 32'(dbg.core_stall), 1);
        tick; dbg.instr_boundary = 0; #1;
        chk("wd_stopped", 32'(dbg.debug_stopped), 0);
        chk("wd_stall", 32'(dbg.core_stall), 0);
        // run beats seize release in STOPPED
        dbg.debug_seize = 1;
        tick; dbg.instr_boundary = 1;
        tick; dbg.instr_boundary = 0;
        dbg.debug_run = 1; dbg.debug_seize = 0; dbg.debug_addr = 8'h77;
        tick; dbg.debug_run = 0; #1;
        chk("race_start", 32'(dbg.ucode_start), 1);
        chk("race_addr", 32'(dbg.ucode_addr), 32'h77);
        chk("race_stopped", 32'(dbg.debug_stopped), 0);
        // asynchronous reset during EXEC
        tick;
        reset = 1; dbg.debug_seize = 1; #1;
        chk_all_zero("areset");
        tick; reset = 0;
        dbg.instr_boundary = 1; #1;
        chk("post_reset_running_stall", 32'(dbg.core_stall), 0);
        tick;
        chk("post_reset_seizing_stall", 32'(dbg.core_stall), 1);
        tick; dbg.instr_boundary = 0; #1;
        chk("post_reset_stopped", 32'(dbg.debug_stopped), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
